traffic_light_controller: RTL and testbench



---
 rtl/tlc_pkg.sv | 25 ++
 rtl/traffic_light_controller.sv | 80 ++++++++
 tb/tb_traffic_light_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// Shared types, field positions and helpers for the four-road traffic light controller.
package tlc_pkg;

    typedef enum logic {
        NORMAL    = 1'b0,
        EMERGENCY = 1'b1
    } state_t;

    localparam int unsigned ROAD_W  = 2;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LIGHT_W = 4;

    localparam int unsigned EMG_BIT  = 2;
    localparam int unsigned ROAD_MSB = 1;

    localparam logic [ROAD_W-1:0] ROAD0 = 2'd0;
    localparam logic [ROAD_W-1:0] ROAD1 = 2'd1;
    localparam logic [ROAD_W-1:0] ROAD2 = 2'd2;
    localparam logic [ROAD_W-1:0] ROAD3 = 2'd3;

    function automatic logic [LIGHT_W-1:0] road_to_onehot(input logic [ROAD_W-1:0] road);
        return LIGHT_W'(1) << road;
    endfunction

endpackage

// File: rtl/traffic_light_controller.sv
// Rotating single-green light controller with manual jump and emergency pre-emption.
module traffic_light_controller
    import tlc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 3,
    parameter int unsigned GREEN_CYCLES     = 1,
    parameter int unsigned EMERGENCY_CYCLES = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] instruction,
    output logic [LIGHT_W-1:0]    lights
);

    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] EMG_LAST   = CNT_W'(EMERGENCY_CYCLES - 1);

    state_t              state_q, state_d;
    logic [ROAD_W-1:0]   road_q,  road_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [ROAD_W-1:0]   target_road;
    logic                is_emg;

    assign target_road = instruction[ROAD_MSB:0];
    assign is_emg      = instruction[EMG_BIT];

    // State, road, dwell counter and the lamp register that mirrors the next road.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NORMAL;
            road_q  <= ROAD0;
            cnt_q   <= '0;
            lights  <= road_to_onehot(ROAD0);
        end else begin
            state_q <= state_d;
            road_q  <= road_d;
            cnt_q   <= cnt_d;
            lights  <= road_to_onehot(road_d);
        end
    end

    // Emergency beats manual; manual is dropped while an emergency hold runs.
    always_comb begin
        state_d = state_q;
        road_d  = road_q;
        cnt_d   = cnt_q;

        if (valid && is_emg) begin
            state_d = EMERGENCY;
            road_d  = target_road;
            cnt_d   = '0;
        end else if (valid && (state_q == NORMAL)) begin
            road_d = target_road;
            cnt_d  = '0;
        end else begin
            unique case (state_q)
                NORMAL: begin
                    if (cnt_q == GREEN_LAST) begin
                        road_d = road_q + ROAD_W'(1);
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                EMERGENCY: begin
                    if (cnt_q == EMG_LAST) begin
                        state_d = NORMAL;
                        road_d  = road_q + ROAD_W'(1);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench: two controller configurations driven by shared directed and random stimulus.
module tb_traffic_light_controller;

    localparam int G_A = 1;
    localparam int E_A = 5;
    localparam int G_B = 3;
    localparam int E_B = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [2:0] instruction;
    logic [3:0] lights_a;
    logic [3:0] lights_b;

    int total = 0;
    int bad   = 0;
    bit stim_done = 1'b0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         step;
    } exp_t;

    exp_t exp_q[$];

    int road_a = 0, rem_a = G_A, emg_a = 0;
    int road_b = 0, rem_b = G_B, emg_b = 0;
    int step_no = 0;

    always #5 clk = ~clk;

    traffic_light_controller #(
        .DATA_WIDTH(3), .GREEN_CYCLES(G_A), .EMERGENCY_CYCLES(E_A)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid),
        .instruction(instruction), .lights(lights_a)
    );

    traffic_light_controller #(
        .DATA_WIDTH(3), .GREEN_CYCLES(G_B), .EMERGENCY_CYCLES(E_B)
    ) dut_b (
        .clk(clk), .reset(reset), .valid(valid),
        .instruction(instruction), .lights(lights_b)
    );

    // Reference: which road is green and how many green cycles it still has left.
    task automatic model(input bit rst, input bit v, input logic [2:0] ins,
                         input int g, input int e,
                         inout int road, inout int rem, inout int emg);
        if (rst) begin
            road = 0; rem = g; emg = 0;
        end else if (v && ins[2]) begin
            road = int'(ins[1:0]); rem = e; emg = 1;
        end else if (v && emg == 0) begin
            road = int'(ins[1:0]); rem = g;
        end else begin
            rem = rem - 1;
            if (rem == 0) begin
                road = (road + 1) % 4;
                emg  = 0;
                rem  = g;
            end
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [2:0] ins);
        exp_t x;
        @(negedge clk);
        reset       = rst;
        valid       = v;
        instruction = ins;
        model(rst, v, ins, G_A, E_A, road_a, rem_a, emg_a);
        model(rst, v, ins, G_B, E_B, road_b, rem_b, emg_b);
        step_no++;
        x.a    = 4'(1 << road_a);
        x.b    = 4'(1 << road_b);
        x.step = step_no;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'($urandom_range(0, 7)));
    endtask

    // Monitor: every edge produces a lamp value, compared against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            total++;
            if (lights_a !== x.a) begin
                bad++;
                $display("FAIL lights_a step %0d: got %b want %b", x.step, lights_a, x.a);
            end
            total++;
            if (lights_b !== x.b) begin
                bad++;
                $display("FAIL lights_b step %0d: got %b want %b", x.step, lights_b, x.b);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        valid       = 1'b0;
        instruction = 3'b000;

        // reset and plain rotation
        step(1'b1, 1'b0, 3'b000);
        step(1'b1, 1'b0, 3'b000);
        idle(6);
        // emergency to road 2
        step(1'b0, 1'b1, 3'b110);
        idle(9);
        // manual jump to road 3
        step(1'b0, 1'b1, 3'b011);
        idle(4);
        // manual ignored during emergency
        step(1'b0, 1'b1, 3'b101);
        idle(1);
        step(1'b0, 1'b1, 3'b000);
        idle(7);
        // emergency re-trigger
        step(1'b0, 1'b1, 3'b100);
        idle(2);
        step(1'b0, 1'b1, 3'b111);
        idle(8);
        // emergency-looking instruction without valid
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'b110);
        // reset mid-emergency
        step(1'b0, 1'b1, 3'b101);
        idle(2);
        step(1'b1, 1'b0, 3'b000);
        idle(5);
        // manual re-select of the green road restarts its period
        step(1'b0, 1'b1, 3'b001);
        idle(1);
        step(1'b0, 1'b1, 3'b001);
        idle(4);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit r, v;
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) == 0);
            step(r, v, 3'($urandom_range(0, 7)));
        end

        stim_done = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
